mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store/fetch interface. Owns the unified
//  Von Neumann byte array. Serves one request at a time over a valid/ready handshake,

---
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: unified byte array served one request at a time over
// valid/ready handshakes, one byte per cycle, big-endian byte order.
module mem_responder #(
    parameter int unsigned MEM_SIZE = 524288,
    parameter int unsigned ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);
    localparam int unsigned IDX_W = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Byte array is deliberately not reset; contents survive reset.
    logic [7:0] bytes [0:MEM_SIZE-1];

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] lim_s;
    logic [ADDR_W-1:0] addr_s;
    logic [IDX_W-1:0]  idx_s;
    logic [2:0]        last_s;
    logic [2:0]        pos_s;
    logic              unused_s;

    // Range limit for the incoming request, plus current byte address and lane.
    always_comb begin
        lim_s  = ADDR_W'(MEM_SIZE) - (req_size ? ADDR_W'(8) : ADDR_W'(4));
        addr_s = addr_q + ADDR_W'(cnt_q);
        idx_s  = addr_s[IDX_W-1:0];
        last_s = size_q ? 3'd7 : 3'd3;
        pos_s  = last_s - cnt_q;
    end

    assign unused_s = ^addr_s[ADDR_W-1:IDX_W];

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 3'd0;
                    rdata_d = 64'd0;
                    if (req_addr > lim_s) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!wr_q) begin
                    rdata_d[{pos_s, 3'b000} +: 8] = bytes[idx_s];
                end else begin
                    rdata_d = rdata_q;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == last_s) begin
                    state_d = RESP;
                end else begin
                    state_d = ACCESS;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            cnt_q   <= 3'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store byte lane; gated by reset_n so an edge inside reset writes nothing.
    always_ff @(posedge clk) begin
        if (reset_n && (state_q == ACCESS) && wr_q) begin
            bytes[idx_s] <= wdata_q[{pos_s, 3'b000} +: 8];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;
    localparam int unsigned MEM_SIZE = 524288;
    localparam int unsigned ADDR_W   = 64;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    int errors = 0;
    int checks = 0;

    mem_responder #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic w, input logic s, input logic [63:0] a, input logic [63:0] d);
        req_write = w;
        req_size  = s;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic txn(input logic w, input logic s, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic e, output int lat);
        start_req(w, s, a, d);
        wait_resp(lat);
        rd = resp_rdata;
        e  = resp_err;
        finish_resp();
    endtask

    logic [63:0] rd;
    logic        e;
    int          lat;
    logic [63:0] held_rd;
    logic        held_e;

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        #12;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        reset_n = 1'b1;
        tick();

        // Fetch: preload via a size-0 store, then fetch it back.
        txn(1'b1, 1'b0, 64'h2000, 64'h0000_0000_1234_5678, rd, e, lat);
        chk("pre_store_err", {63'd0, e}, 64'd0);
        chk("pre_store_rdata", rd, 64'd0);
        chk("pre_byte0", {56'd0, dut.bytes[32'h2000]}, 64'h12);
        chk("pre_byte3", {56'd0, dut.bytes[32'h2003]}, 64'h78);
        chk("ready_after_resp", {63'd0, req_ready}, 64'd1);
        txn(1'b0, 1'b0, 64'h2000, 64'd0, rd, e, lat);
        chk("fetch_lat", 64'(lat), 64'd4);
        chk("fetch_rdata", rd, 64'h0000_0000_1234_5678);
        chk("fetch_err", {63'd0, e}, 64'd0);

        // Data store then load.
        txn(1'b1, 1'b1, 64'h10000, 64'h0123_4567_89AB_CDEF, rd, e, lat);
        chk("st8_lat", 64'(lat), 64'd8);
        chk("st8_err", {63'd0, e}, 64'd0);
        chk("st8_byte0", {56'd0, dut.bytes[32'h10000]}, 64'h01);
        chk("st8_byte7", {56'd0, dut.bytes[32'h10007]}, 64'hEF);
        txn(1'b0, 1'b1, 64'h10000, 64'd0, rd, e, lat);
        chk("ld8_lat", 64'(lat), 64'd8);
        chk("ld8_rdata", rd, 64'h0123_4567_89AB_CDEF);

        // Range boundaries.
        txn(1'b1, 1'b0, 64'(MEM_SIZE - 4), 64'h0000_0000_CAFE_BABE, rd, e, lat);
        chk("edge4_store_err", {63'd0, e}, 64'd0);
        txn(1'b1, 1'b1, 64'(MEM_SIZE - 4), 64'hFFFF_FFFF_FFFF_FFFF, rd, e, lat);
        chk("oor8_lat", 64'(lat), 64'd0);
        chk("oor8_err", {63'd0, e}, 64'd1);
        chk("oor8_rdata", rd, 64'd0);
        txn(1'b0, 1'b0, 64'(MEM_SIZE - 4), 64'd0, rd, e, lat);
        chk("edge4_load_lat", 64'(lat), 64'd4);
        chk("edge4_load_err", {63'd0, e}, 64'd0);
        chk("edge4_unchanged", rd, 64'h0000_0000_CAFE_BABE);
        txn(1'b0, 1'b1, 64'(MEM_SIZE - 8), 64'd0, rd, e, lat);
        chk("edge8_load_err", {63'd0, e}, 64'd0);
        txn(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, rd, e, lat);
        chk("wrap_err", {63'd0, e}, 64'd1);
        chk("wrap_rdata", rd, 64'd0);

        // Backpressure with a competing request held during RESP.
        start_req(1'b0, 1'b1, 64'h10000, 64'd0);
        wait_resp(lat);
        held_rd = resp_rdata;
        held_e  = resp_err;
        chk("bp_rdata", held_rd, 64'h0123_4567_89AB_CDEF);
        req_write = 1'b1;
        req_size  = 1'b1;
        req_addr  = 64'h10000;
        req_wdata = 64'h5555_5555_5555_5555;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_hold_rdata", resp_rdata, held_rd);
            chk("bp_hold_err", {63'd0, resp_err}, {63'd0, held_e});
        end
        req_valid = 1'b0;
        finish_resp();
        chk("bp_released", {63'd0, resp_valid}, 64'd0);
        tick();
        tick();
        chk("bp_no_accept", {63'd0, resp_valid}, 64'd0);
        txn(1'b0, 1'b1, 64'h10000, 64'd0, rd, e, lat);
        chk("bp_mem_intact", rd, 64'h0123_4567_89AB_CDEF);

        // Reset while a response is pending.
        start_req(1'b0, 1'b0, 64'h2000, 64'd0);
        wait_resp(lat);
        chk("pend_rdata", resp_rdata, 64'h0000_0000_1234_5678);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_rdata", resp_rdata, 64'd0);
        chk("midrst_err", {63'd0, resp_err}, 64'd0);
        #2;
        reset_n = 1'b1;
        tick();

        // Abort a store after three bytes.
        txn(1'b1, 1'b1, 64'h3000, 64'd0, rd, e, lat);
        start_req(1'b1, 1'b1, 64'h3000, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_valid", {63'd0, resp_valid}, 64'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_resp", {63'd0, resp_valid}, 64'd0);
        end
        chk("abort_byte2", {56'd0, dut.bytes[32'h3002]}, 64'hAA);
        chk("abort_byte3", {56'd0, dut.bytes[32'h3003]}, 64'h00);
        txn(1'b0, 1'b1, 64'h3000, 64'd0, rd, e, lat);
        chk("abort_region", rd, 64'hAAAA_AA00_0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
